crank_wheel_gen: RTL and testbench
==================================

// Module: crank_wheel_gen
// PURPOSE
//  Synthetic crank trigger-wheel transmitter: produces a square VR-style tooth signal with a missing-tooth
//  gap (default 60-2) for the hwag vr_in input. Bench/bring-up stimulus source and in-FPGA self-test
//  generator; the transmit end of the signal that hwag decodes. Tooth period is programmable at run time.
// PARAMETERS
//  TOOTH_CNT  60  tooth positions per revolution, including missing ones (2..256)
//  GAP_CNT    2   missing teeth at the end of each revolution (1..TOOTH_CNT-2)
//  PERIOD_W   24  width of the tooth-period input, in clk cycles
// PORTS
//  clk        in   1         system clock
//  rst        in   1         synchronous reset, active high
//  en         in   1         run request; sampled in IDLE and at each tooth boundary
//  period     in   PERIOD_W  clk cycles per tooth position (high + low)
//  vr_out     out  1         generated tooth signal, registered
//  tooth_num  out  8         current tooth position 0..TOOTH_CNT-1, registered
//  gap_flag   out  1         1 while the current position is a missing tooth
//  rev_pulse  out  1         1-cycle pulse on the first cycle of tooth 0
//  busy       out  1         1 when not in IDLE
// BEHAVIOUR
//  Reset: state=IDLE; vr_out=0, tooth_num=0, gap_flag=0, rev_pulse=0, busy=0; counters and shadow period 0.
//  rst has priority over everything; asserting it mid-tooth aborts at the next edge (outputs as above).
//  Shadow period P = max(period,2), latched only when a tooth starts; changes mid-tooth take effect next tooth.
//  Per tooth: H = P>>1 cycles high, L = P-H cycles low (odd P: low half is one longer). Tooth = exactly P cycles.
//  FSM states: IDLE, HIGH, LOW, GAP.
//   IDLE: en=1 at cycle t -> at t+1 state=HIGH, tooth_num=0, vr_out=1, rev_pulse=1, busy=1, P latched.
//   HIGH: vr_out=1 for H cycles, then LOW.
//   LOW : vr_out=0 for L cycles, then tooth boundary.
//   GAP : vr_out=0, gap_flag=1 for P cycles, then tooth boundary.
//  Tooth boundary (last cycle of LOW/GAP): en=0 -> IDLE next cycle (tooth_num->0, busy->0);
//   en=1 -> tooth_num = (tooth_num==TOOTH_CNT-1) ? 0 : tooth_num+1, relatch P, next state GAP if
//   new tooth_num >= TOOTH_CNT-GAP_CNT else HIGH. No idle cycle between teeth.
//  en deasserted mid-tooth never truncates the tooth; the tooth completes, then IDLE.
//  rev_pulse asserts on the first cycle of every tooth 0 (including start from IDLE); never 2 cycles wide.
//  Revolution length = TOOTH_CNT*P cycles; (TOOTH_CNT-GAP_CNT) rising edges of vr_out per revolution.
//  Gap low time = GAP_CNT*P + L cycles (last real tooth's low half plus missing positions).
//  Internal cycle counter is PERIOD_W bits, counts up from 0, compared against H-1 / P-1; no overflow possible.
//  All outputs are registered; no combinational path from inputs to outputs.
// TESTING
//  1 period=10, en=1 held: vr_out 5 high/5 low x58 teeth, then 25-cycle low gap; rev_pulse every 600 cycles.
//  2 period=7: each real tooth 3 high/4 low; tooth_num walks 0..59 and wraps to 0 with rev_pulse=1.
//  3 period=0 and period=1: behave as P=2 (1 high/1 low); gap positions 2 cycles each.
//  4 period 10->20 written mid-tooth 5: tooth 5 stays 10 cycles, tooth 6 onward 20 cycles (10/10).
//  5 en dropped mid-HIGH of tooth 12: tooth 12 finishes its 10 cycles, then IDLE, vr_out=0, tooth_num=0, busy=0;
//    en reasserted -> restarts at tooth 0 with rev_pulse.
//  6 rst pulsed during GAP (tooth 58): next cycle all outputs at reset values; en=1 restarts at tooth 0.

Source files
------------

// File: rtl/crank_wheel_gen_if.sv
// rtl/crank_wheel_gen_if.sv - run/period control and tooth-signal outputs of the crank wheel generator
interface crank_wheel_gen_if #(
  parameter int PERIOD_W = 24
);
  logic                en;
  logic [PERIOD_W-1:0] period;
  logic                vr_out;
  logic [7:0]          tooth_num;
  logic                gap_flag;
  logic                rev_pulse;
  logic                busy;

  modport master (
    output en, period,
    input  vr_out, tooth_num, gap_flag, rev_pulse, busy
  );

  modport slave (
    input  en, period,
    output vr_out, tooth_num, gap_flag, rev_pulse, busy
  );
endinterface

// File: rtl/crank_wheel_gen.sv
// rtl/crank_wheel_gen.sv - synthetic missing-tooth crank trigger wheel transmitter
module crank_wheel_gen #(
  parameter int TOOTH_CNT = 60,
  parameter int GAP_CNT   = 2,
  parameter int PERIOD_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  crank_wheel_gen_if.slave cw
);
  typedef logic [PERIOD_W-1:0] per_t;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  localparam per_t       ONE       = per_t'(1);
  localparam per_t       TWO       = per_t'(2);
  localparam logic [7:0] LAST      = 8'(TOOTH_CNT - 1);
  localparam logic [7:0] GAP_START = 8'(TOOTH_CNT - GAP_CNT);

  state_t     state_q, state_d;
  per_t       cnt_q, cnt_d;
  per_t       per_q, per_d;
  logic [7:0] tooth_q, tooth_d;
  logic       vr_q, vr_d;
  logic       gap_q, gap_d;
  logic       rev_q, rev_d;
  logic       busy_q, busy_d;

  per_t       per_new;
  per_t       half;
  logic [7:0] tooth_nx;

  // Shadow period clamps to 2 so both halves are at least one cycle.
  assign per_new  = (cw.period < TWO) ? TWO : cw.period;
  assign half     = per_q >> 1;
  assign tooth_nx = (tooth_q == LAST) ? 8'd0 : tooth_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      tooth_q <= '0;
      vr_q    <= 1'b0;
      gap_q   <= 1'b0;
      rev_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      tooth_q <= tooth_d;
      vr_q    <= vr_d;
      gap_q   <= gap_d;
      rev_q   <= rev_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + ONE;
    per_d   = per_q;
    tooth_d = tooth_q;
    vr_d    = vr_q;
    gap_d   = gap_q;
    rev_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cw.en) begin
          state_d = S_HIGH;
          tooth_d = 8'd0;
          per_d   = per_new;
          vr_d    = 1'b1;
          gap_d   = 1'b0;
          rev_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == half - ONE) begin
          state_d = S_LOW;
          vr_d    = 1'b0;
        end
      end
      default: begin
        // The counter runs across the whole tooth, so LOW and GAP share the P-1 boundary.
        if (cnt_q == per_q - ONE) begin
          cnt_d = '0;
          if (!cw.en) begin
            state_d = S_IDLE;
            tooth_d = 8'd0;
            vr_d    = 1'b0;
            gap_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            tooth_d = tooth_nx;
            per_d   = per_new;
            rev_d   = (tooth_nx == 8'd0);
            if (tooth_nx >= GAP_START) begin
              state_d = S_GAP;
              vr_d    = 1'b0;
              gap_d   = 1'b1;
            end else begin
              state_d = S_HIGH;
              vr_d    = 1'b1;
              gap_d   = 1'b0;
            end
          end
        end
      end
    endcase
  end

  assign cw.vr_out    = vr_q;
  assign cw.tooth_num = tooth_q;
  assign cw.gap_flag  = gap_q;
  assign cw.rev_pulse = rev_q;
  assign cw.busy      = busy_q;
endmodule

// File: tb/tb_crank_wheel_gen.sv
// tb/tb_crank_wheel_gen.sv - bench for crank_wheel_gen against a tooth-position reference model
module tb_crank_wheel_gen;
  localparam int TC = 60;
  localparam int GC = 2;
  localparam int PW = 24;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: which tooth, how far into it, and the period latched for it.
  bit   m_run;
  int   m_tooth, m_k, m_p;

  // Waveform statistics taken from the DUT output.
  int   rises, low_run, max_low;
  bit   prev_vr;

  crank_wheel_gen_if #(.PERIOD_W(PW)) cw();

  crank_wheel_gen #(.TOOTH_CNT(TC), .GAP_CNT(GC), .PERIOD_W(PW)) dut (
    .clk (clk),
    .rst (rst),
    .cw  (cw)
  );

  always #5 clk = ~clk;

  function automatic int clamp_p(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_run = 0; m_tooth = 0; m_k = 0; m_p = 0;
    end else if (!m_run) begin
      if (cw.en) begin
        m_run = 1; m_tooth = 0; m_k = 0; m_p = clamp_p(int'(cw.period));
      end
    end else if (m_k == m_p - 1) begin
      m_k = 0;
      if (!cw.en) begin
        m_run = 0; m_tooth = 0;
      end else begin
        m_tooth = (m_tooth + 1) % TC;
        m_p = clamp_p(int'(cw.period));
      end
    end else begin
      m_k++;
    end
  endtask

  task automatic check();
    logic [11:0] exp_v, got_v;
    bit gapt;
    gapt  = m_run && (m_tooth >= TC - GC);
    exp_v = {m_run && !gapt && (m_k < m_p / 2), gapt, m_run && m_k == 0 && m_tooth == 0,
             m_run, 8'(m_tooth)};
    got_v = {cw.vr_out, cw.gap_flag, cw.rev_pulse, cw.busy, cw.tooth_num};
    vectors++;
    assert (got_v === exp_v) else begin
      miscompares++;
      $error("FAIL outputs {vr,gap,rev,busy,tooth} t=%0t got=%03h exp=%03h", $time, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check();
    if (cw.vr_out && !prev_vr) rises++;
    if (!cw.vr_out) begin
      low_run++;
      if (low_run > max_low) max_low = low_run;
    end else begin
      low_run = 0;
    end
    prev_vr = cw.vr_out;
  endtask

  task automatic bound_check(input string tag, input int n, input int limit);
    vectors++;
    assert (n < limit) else begin
      miscompares++;
      $error("FAIL %s wait expired got=%0d cycles limit=%0d", tag, n, limit);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; cw.en = 1'b0; cw.period = PW'(10);
    m_run = 0; m_tooth = 0; m_k = 0; m_p = 0;
    prev_vr = 0; rises = 0; low_run = 0; max_low = 0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Period 10, en held: 58 real teeth and a 25-cycle gap per 600-cycle revolution.
    cw.en = 1'b1;
    rises = 0; max_low = 0; low_run = 0;
    repeat (600) tick();
    vectors++;
    assert (rises === 58) else begin
      miscompares++;
      $error("FAIL rises_per_rev got=%0d exp=58", rises);
    end
    vectors++;
    assert (max_low === 25) else begin
      miscompares++;
      $error("FAIL gap_low_time got=%0d exp=25", max_low);
    end
    tick();
    vectors++;
    assert (cw.rev_pulse === 1'b1) else begin
      miscompares++;
      $error("FAIL rev_at_600 got=%0b exp=1", cw.rev_pulse);
    end
    repeat (599) tick();

    // Odd period and the clamped minimum periods.
    cw.period = PW'(7);
    repeat (7 * TC + 20) tick();
    cw.period = PW'(0);
    repeat (150) tick();
    cw.period = PW'(1);
    repeat (150) tick();

    // Period change in the middle of tooth 5.
    cw.period = PW'(10);
    n = 0;
    while (!(m_tooth == 5 && m_k == 3 && m_p == 10) && n < 2000) begin tick(); n++; end
    bound_check("reach_tooth5", n, 2000);
    cw.period = PW'(20);
    repeat (300) tick();

    // en dropped mid-HIGH of tooth 12, then restart.
    cw.period = PW'(10);
    n = 0;
    while (!(m_tooth == 12 && m_k == 2 && m_p == 10) && n < 5000) begin tick(); n++; end
    bound_check("reach_tooth12", n, 5000);
    cw.en = 1'b0;
    n = 0;
    while (m_run && n < 50) begin tick(); n++; end
    bound_check("reach_idle", n, 50);
    repeat (5) tick();
    cw.en = 1'b1;
    repeat (30) tick();

    // Reset pulse inside the gap.
    n = 0;
    while (!(m_tooth == 58 && m_k == 4) && n < 1000) begin tick(); n++; end
    bound_check("reach_gap", n, 1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (30) tick();

    // Random en/period/rst activity.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) cw.en = ~cw.en;
      if ($urandom_range(0, 49) == 0) cw.period = PW'($urandom_range(0, 12));
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
